// File: rtl/pr_region_scheduler.sv
// pr_region_scheduler: sequences partial reconfiguration of one region at a time.
// Blocks dispatch to the target region, waits for its queue to drain, isolates it,
// runs the PR engine, releases isolation, answers the requester and keeps the
// authoritative region -> operator-ID table.
module pr_region_scheduler #(
    parameter int OPERATOR_ID_WIDTH = 4,
    parameter int N_REGIONS         = 4,
    parameter int QDEPTH            = 16,
    parameter int DRAIN_HOLD        = 2,
    parameter int DECOUPLE_CYCLES   = 4,
    parameter int PR_TIMEOUT        = 1024
) (
    input  logic                                                    aclk,
    input  logic                                                    areset,
    input  logic [N_REGIONS*(OPERATOR_ID_WIDTH+$clog2(QDEPTH))-1:0] region_stats_in,
    input  logic                                                    req_valid,
    output logic                                                    req_ready,
    input  logic [OPERATOR_ID_WIDTH-1:0]                            req_oid,
    input  logic [$clog2(N_REGIONS):0]                              req_region,
    output logic                                                    rsp_valid,
    input  logic                                                    rsp_ready,
    output logic                                                    rsp_ok,
    output logic [N_REGIONS-1:0]                                    region_block,
    output logic [N_REGIONS-1:0]                                    decouple,
    output logic                                                    pr_start,
    output logic [OPERATOR_ID_WIDTH-1:0]                            pr_oid,
    output logic [$clog2(N_REGIONS)-1:0]                            pr_region,
    input  logic                                                    pr_done,
    input  logic                                                    pr_error,
    output logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0]                  region_oid_out,
    output logic                                                    busy
);
    localparam int OW        = OPERATOR_ID_WIDTH;
    localparam int PNTR_BITS = $clog2(QDEPTH);
    localparam int W         = OW + PNTR_BITS;
    localparam int RB        = $clog2(N_REGIONS);
    localparam int RW        = RB + 1;
    // one counter serves drain hold, settle windows and the PR timeout
    localparam int CW        = $clog2(PR_TIMEOUT + DECOUPLE_CYCLES + DRAIN_HOLD + 2) + 1;
    localparam logic [OW-1:0] INVALID = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_DECOUPLE, S_PROGRAM, S_RECOUPLE, S_RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [OW-1:0]                  oid_q, oid_d;
    logic [RW-1:0]                  region_q, region_d;
    logic                           ok_q, ok_d;
    logic                           blk_q, blk_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [N_REGIONS-1:0][OW-1:0]   table_q, table_d;

    logic [PNTR_BITS-1:0]           cur_load;
    logic [OW-1:0]                  cur_oid;
    logic                           in_range;
    logic [CW-1:0]                  cnt_inc;
    logic [N_REGIONS*OW-1:0]        unused_stats_oid;

    // the OID half of the stats bus is informational only; routing uses our own table
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++)
            unused_stats_oid[i*OW +: OW] = region_stats_in[i*W + PNTR_BITS +: OW];
    end

    // state and datapath registers; async reset aborts any operation silently
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= S_IDLE;
            oid_q    <= '0;
            region_q <= '0;
            ok_q     <= 1'b0;
            blk_q    <= 1'b0;
            cnt_q    <= '0;
            table_q  <= {N_REGIONS{INVALID}};
        end else begin
            state_q  <= state_d;
            oid_q    <= oid_d;
            region_q <= region_d;
            ok_q     <= ok_d;
            blk_q    <= blk_d;
            cnt_q    <= cnt_d;
            table_q  <= table_d;
        end
    end

    // next-state logic: request decode, drain hold, settle windows, PR wait, response
    always_comb begin
        state_d  = state_q;
        oid_d    = oid_q;
        region_d = region_q;
        ok_d     = ok_q;
        blk_d    = blk_q;
        cnt_d    = cnt_q;
        table_d  = table_q;
        cnt_inc  = cnt_q + 1'b1;
        in_range = (req_region < RW'(N_REGIONS));
        cur_load = '0;
        cur_oid  = INVALID;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (region_q == RW'(i))   cur_load = region_stats_in[i*W +: PNTR_BITS];
            if (req_region == RW'(i)) cur_oid  = table_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    oid_d    = req_oid;
                    region_d = req_region;
                    cnt_d    = '0;
                    if (!in_range) begin
                        ok_d    = 1'b0;
                        state_d = S_RESP;
                    end else if (cur_oid == req_oid) begin
                        ok_d    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        blk_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // a nonzero load restarts the consecutive-empty count
                if (cur_load == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CW'(DRAIN_HOLD)) begin
                        cnt_d   = '0;
                        state_d = S_DECOUPLE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_DECOUPLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= CW'(DECOUPLE_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = S_PROGRAM;
                end
            end
            S_PROGRAM: begin
                // done wins over a simultaneous timeout, error wins over done
                if (pr_done || pr_error || cnt_q == CW'(PR_TIMEOUT)) begin
                    ok_d    = pr_done && !pr_error;
                    table_d[region_q[RB-1:0]] = (pr_done && !pr_error) ? oid_q : INVALID;
                    cnt_d   = '0;
                    state_d = S_RECOUPLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RECOUPLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= CW'(DECOUPLE_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    blk_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decode straight from reset flops so reset clears isolation at once
    always_comb begin
        req_ready = (state_q == S_IDLE) && !areset;
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_ok    = (state_q == S_RESP) && ok_q;
        pr_start  = (state_q == S_PROGRAM) && (cnt_q == '0);
        pr_oid    = oid_q;
        pr_region = region_q[RB-1:0];
        region_oid_out = table_q;
        for (int i = 0; i < N_REGIONS; i++) begin
            region_block[i] = blk_q && (region_q == RW'(i));
            decouple[i]     = (state_q == S_DECOUPLE || state_q == S_PROGRAM) &&
                              (region_q == RW'(i));
        end
    end
endmodule

// File: tb/tb_pr_region_scheduler.sv
// Directed bench for pr_region_scheduler: vector table for single-cycle requests,
// hand-written sequences for the multi-cycle reconfiguration paths.
module tb_pr_region_scheduler;
    localparam int NR = 4;
    localparam int W  = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] region_stats_in;
    logic        req_valid, req_ready;
    logic [3:0]  req_oid;
    logic [2:0]  req_region;
    logic        rsp_valid, rsp_ready, rsp_ok;
    logic [3:0]  region_block, decouple;
    logic        pr_start;
    logic [3:0]  pr_oid;
    logic [1:0]  pr_region;
    logic        pr_done, pr_error;
    logic [15:0] region_oid_out;
    logic        busy;

    logic [3:0]  tb_load [NR];
    logic [3:0]  tb_oid  [NR];

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] oid;
        logic [2:0] region;
        logic       ok;
    } qvec_t;
    qvec_t qv [5];

    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < NR; i++) region_stats_in[i*W +: W] = {tb_oid[i], tb_load[i]};
    end

    pr_region_scheduler dut (
        .aclk(aclk), .areset(areset), .region_stats_in(region_stats_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_oid(req_oid),
        .req_region(req_region), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ok(rsp_ok), .region_block(region_block), .decouple(decouple),
        .pr_start(pr_start), .pr_oid(pr_oid), .pr_region(pr_region),
        .pr_done(pr_done), .pr_error(pr_error), .region_oid_out(region_oid_out),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [3:0] oid, input logic [2:0] region);
        req_valid  = 1'b1;
        req_oid    = oid;
        req_region = region;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic run_to_program(input string name, input logic [3:0] oid, input logic [2:0] region);
        send(oid, region);
        for (int k = 0; k < 40 && !pr_start; k++) step();
        chk({name, "_pr_start"}, 32'(pr_start), 'h1);
    endtask

    task automatic finish_rsp(input string name, input logic exp_ok);
        for (int k = 0; k < 40 && !rsp_valid; k++) step();
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 'h1);
        chk({name, "_rsp_ok"}, 32'(rsp_ok), 32'(exp_ok));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({name, "_rsp_done"}, 32'({rsp_valid, region_block}), 'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        qv[0] = '{oid: 4'd5,  region: 3'd1, ok: 1'b1};
        qv[1] = '{oid: 4'hF,  region: 3'd0, ok: 1'b1};
        qv[2] = '{oid: 4'd0,  region: 3'd4, ok: 1'b0};
        qv[3] = '{oid: 4'd5,  region: 3'd7, ok: 1'b0};
        qv[4] = '{oid: 4'd9,  region: 3'd5, ok: 1'b0};

        req_valid = 1'b0; req_oid = '0; req_region = '0;
        rsp_ready = 1'b0; pr_done = 1'b0; pr_error = 1'b0;
        for (int i = 0; i < NR; i++) begin tb_load[i] = '0; tb_oid[i] = '0; end
        tb_load[1] = 4'd3; tb_oid[1] = 4'd6;

        // reset state
        step(); step();
        chk("rst_outputs", 32'({rsp_valid, rsp_ok, pr_start, busy, region_block, decouple}), 'h0);
        chk("rst_pr_target", 32'({pr_oid, pr_region}), 'h0);
        chk("rst_table", 32'(region_oid_out), 'hFFFF);
        areset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 'h1);

        // full reconfiguration of region 1 with OID 5
        send(4'd5, 3'd1);
        chk("full_block", 32'(region_block), 'h2);
        chk("full_busy_noready", 32'({busy, req_ready}), 'h2);
        step(); step();
        chk("full_hold_while_loaded", 32'(decouple), 'h0);
        tb_load[1] = 4'd0;
        step();
        chk("full_hold_one_zero", 32'(decouple), 'h0);
        step();
        chk("full_decouple", 32'(decouple), 'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_pr_start_early", 32'(pr_start), 'h0);
        end
        step();
        chk("full_pr_start", 32'({pr_start, pr_oid, pr_region}), 32'({1'b1, 4'd5, 2'd1}));
        step();
        chk("full_pr_start_pulse", 32'(pr_start), 'h0);
        repeat (8) step();
        chk("full_table_before_done", 32'(region_oid_out), 'hFFFF);
        chk("full_decouple_held", 32'(decouple), 'h2);
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
        chk("full_table_after_done", 32'(region_oid_out), 'hFF5F);
        chk("full_recouple", 32'({decouple, region_block}), 'h02);
        repeat (3) step();
        chk("full_no_early_rsp", 32'(rsp_valid), 'h0);
        step();
        chk("full_rsp", 32'({rsp_valid, rsp_ok, region_block}), 32'({2'b11, 4'b0010}));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("full_after_handshake", 32'({rsp_valid, busy, region_block}), 'h0);

        // single-cycle requests: no-ops and out-of-range regions
        for (int v = 0; v < 5; v++) begin
            send(qv[v].oid, qv[v].region);
            chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 'h1);
            chk($sformatf("vec%0d_rsp_ok", v), 32'(rsp_ok), 32'(qv[v].ok));
            chk($sformatf("vec%0d_quiet", v), 32'({region_block, decouple, pr_start}), 'h0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk($sformatf("vec%0d_idle", v), 32'({busy, rsp_valid}), 'h0);
        end
        chk("vec_table", 32'(region_oid_out), 'hFF5F);

        // drain glitch: loads 0,1,0,0 on region 2
        send(4'd7, 3'd2);
        step();
        tb_load[2] = 4'd1;
        step();
        tb_load[2] = 4'd0;
        step();
        chk("glitch_no_early_decouple", 32'(decouple), 'h0);
        step();
        chk("glitch_decouple", 32'(decouple), 'h4);
        for (int k = 0; k < 10 && !pr_start; k++) step();
        chk("glitch_pr_start", 32'(pr_start), 'h1);
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
        chk("glitch_table", 32'(region_oid_out), 'hF75F);
        finish_rsp("glitch", 1'b1);

        // PR error clears the entry
        run_to_program("err", 4'd8, 3'd2);
        pr_error = 1'b1;
        step();
        pr_error = 1'b0;
        chk("err_table", 32'(region_oid_out), 'hFF5F);
        finish_rsp("err", 1'b0);

        // done and error together is a failure
        run_to_program("both", 4'd3, 3'd1);
        pr_done = 1'b1; pr_error = 1'b1;
        step();
        pr_done = 1'b0; pr_error = 1'b0;
        chk("both_table", 32'(region_oid_out), 'hFFFF);
        finish_rsp("both", 1'b0);

        // response backpressure with a competing request
        run_to_program("bp", 4'd9, 3'd0);
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
        for (int k = 0; k < 20 && !rsp_valid; k++) step();
        req_valid = 1'b1; req_oid = 4'd2; req_region = 3'd3;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", 32'({rsp_valid, rsp_ok, req_ready}), 'h6);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        chk("bp_not_accepted", 32'({busy, rsp_valid, region_block}), 'h0);
        chk("bp_table", 32'(region_oid_out), 'hFFF9);

        // reset during PROGRAM aborts without a response
        run_to_program("rstop", 4'd4, 3'd2);
        step(); step();
        areset = 1'b1;
        #1;
        chk("rstop_immediate", 32'({decouple, region_block, busy}), 'h0);
        step();
        areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rstop_no_rsp", 32'({rsp_valid, busy}), 'h0);
        end
        chk("rstop_table", 32'(region_oid_out), 'hFFFF);

        // stray completion outside PROGRAM is ignored
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
        chk("stray_done", 32'({busy, region_oid_out}), 'hFFFF);

        // timeout: give region 0 a valid entry first so the failure is visible
        run_to_program("pre_to", 4'd1, 3'd0);
        pr_done = 1'b1;
        step();
        pr_done = 1'b0;
        finish_rsp("pre_to", 1'b1);
        chk("pre_to_table", 32'(region_oid_out), 'hFFF1);
        run_to_program("to", 4'd3, 3'd0);
        repeat (1024) step();
        chk("to_still_waiting", 32'({decouple, region_oid_out}), 'h1FFF1);
        step();
        chk("to_fires", 32'({decouple, region_oid_out}), 'h0FFFF);
        finish_rsp("to", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
